// File: rtl/rgb_layer_mux_if.sv
// Pixel-side signal bundle for rgb_layer_mux: layer inputs from the pixel
// generators and the aligned VGA outputs.
interface rgb_layer_mux_if #(
   parameter int COLOR_W = 12,
   parameter int LAYERS  = 4
);
   logic                        video_on;
   logic                        hsync_in;
   logic                        vsync_in;
   logic [LAYERS*COLOR_W-1:0]   layer_color;
   logic [LAYERS-1:0]           layer_valid;
   logic [LAYERS-1:0]           layer_blink;
   logic                        blink_en;
   logic [COLOR_W-1:0]          RGB;
   logic                        hsync_out;
   logic                        vsync_out;
   logic                        video_on_out;
   logic                        blink_phase;

   modport master (
      output video_on, hsync_in, vsync_in, layer_color, layer_valid, layer_blink, blink_en,
      input  RGB, hsync_out, vsync_out, video_on_out, blink_phase
   );

   modport slave (
      input  video_on, hsync_in, vsync_in, layer_color, layer_valid, layer_blink, blink_en,
      output RGB, hsync_out, vsync_out, video_on_out, blink_phase
   );
endinterface

// File: rtl/rgb_layer_mux.sv
// Two-stage VGA pixel output: priority layer select with frame-counted
// blinking, then blanking, with syncs delayed to stay aligned with RGB.
module rgb_layer_mux #(
   parameter int                 COLOR_W      = 12,
   parameter int                 LAYERS       = 4,
   parameter logic [COLOR_W-1:0] BG_COLOR     = '0,
   parameter int                 BLINK_FRAMES = 30,
   parameter logic               SYNC_ACTIVE  = 1'b0
) (
   input  logic           clk,
   input  logic           reset_n,
   rgb_layer_mux_if.slave pix
);

   localparam int               CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLINK_FRAMES - 1);

   logic [COLOR_W-1:0] sel_color;
   logic [COLOR_W-1:0] s1_color;
   logic               s1_video;
   logic               s1_hsync;
   logic               s1_vsync;
   logic [COLOR_W-1:0] rgb_q;
   logic               hsync_q;
   logic               vsync_q;
   logic               video_q;
   logic               vsync_prev;
   logic [CNT_W-1:0]   count;
   logic               phase;
   logic               frame_start;

   // Walk from lowest priority upward so the lowest-index eligible layer wins.
   always_comb begin
      sel_color = BG_COLOR;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (pix.layer_valid[i] && (!pix.layer_blink[i] || phase))
            sel_color = pix.layer_color[i*COLOR_W +: COLOR_W];
      end
   end

   assign frame_start = (pix.vsync_in == SYNC_ACTIVE) && (vsync_prev != SYNC_ACTIVE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_color <= '0;
         s1_video <= 1'b0;
         s1_hsync <= ~SYNC_ACTIVE;
         s1_vsync <= ~SYNC_ACTIVE;
         rgb_q    <= '0;
         video_q  <= 1'b0;
         hsync_q  <= ~SYNC_ACTIVE;
         vsync_q  <= ~SYNC_ACTIVE;
      end else begin
         s1_color <= sel_color;
         s1_video <= pix.video_on;
         s1_hsync <= pix.hsync_in;
         s1_vsync <= pix.vsync_in;
         rgb_q    <= s1_video ? s1_color : '0;
         video_q  <= s1_video;
         hsync_q  <= s1_hsync;
         vsync_q  <= s1_vsync;
      end
   end

   // Phase flips once every BLINK_FRAMES frame starts; disabling blink pins it visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vsync_prev <= ~SYNC_ACTIVE;
         count      <= '0;
         phase      <= 1'b1;
      end else begin
         vsync_prev <= pix.vsync_in;
         if (!pix.blink_en) begin
            count <= '0;
            phase <= 1'b1;
         end else if (frame_start) begin
            if (count == LAST) begin
               count <= '0;
               phase <= ~phase;
            end else begin
               count <= count + CNT_W'(1);
            end
         end
      end
   end

   assign pix.RGB          = rgb_q;
   assign pix.hsync_out    = hsync_q;
   assign pix.vsync_out    = vsync_q;
   assign pix.video_on_out = video_q;
   assign pix.blink_phase  = phase;

endmodule

// File: tb/tb_rgb_layer_mux.sv
// Directed bench for rgb_layer_mux with BLINK_FRAMES=2 and active-low syncs;
// inputs are driven and outputs sampled on the falling clock edge.
module tb_rgb_layer_mux;

   logic clk;
   logic reset_n;
   int   check_count;
   int   fail_count;

   rgb_layer_mux_if #(.COLOR_W(12), .LAYERS(4)) bus ();

   rgb_layer_mux #(
      .COLOR_W(12), .LAYERS(4), .BG_COLOR(12'h000),
      .BLINK_FRAMES(2), .SYNC_ACTIVE(1'b0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pix(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic video, input logic hs, input logic vs,
                                input logic [3:0] valid, input logic [3:0] blink, input logic en);
      bus.video_on    = video;
      bus.hsync_in    = hs;
      bus.vsync_in    = vs;
      bus.layer_valid = valid;
      bus.layer_blink = blink;
      bus.blink_en    = en;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // One vsync low pulse; layer0=0x00F blinking over layer1=0x0F0 steady.
   task automatic vsyncPulse(input string tag, input logic exp_phase, input logic old_phase);
      bus.vsync_in = 1'b0;
      step(1);
      checkOutput({tag, "_phase"}, 32'(bus.blink_phase), 32'(exp_phase));
      step(1);
      checkOutput({tag, "_rgb_old"}, 32'(bus.RGB), old_phase ? 32'h00F : 32'h0F0);
      checkOutput({tag, "_vsync"}, 32'(bus.vsync_out), 32'h0);
      step(1);
      bus.vsync_in = 1'b1;
      step(5);
      checkOutput({tag, "_rgb_new"}, 32'(bus.RGB), exp_phase ? 32'h00F : 32'h0F0);
   endtask

   logic [3:0]  blank_vid [4];
   logic [11:0] blank_exp [4];

   initial begin
      check_count = 0;
      fail_count  = 0;
      blank_vid = '{1'b1, 1'b0, 1'b1, 1'b1};
      blank_exp = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};

      // Reset with random inputs
      reset_n = 1'b0;
      bus.layer_color = '0;
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.layer_color = 48'({$urandom, $urandom});
         applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         step(1);
      end
      checkOutput("rst_rgb",   32'(bus.RGB), 32'h0);
      checkOutput("rst_hsync", 32'(bus.hsync_out), 32'h1);
      checkOutput("rst_vsync", 32'(bus.vsync_out), 32'h1);
      checkOutput("rst_video", 32'(bus.video_on_out), 32'h0);
      checkOutput("rst_phase", 32'(bus.blink_phase), 32'h1);

      // Release and track constant inputs
      bus.layer_color = {12'h000, 12'h000, 12'h000, 12'hABC};
      applyStimulus(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0);
      reset_n = 1'b1;
      step(1);
      checkOutput("rel1_rgb",   32'(bus.RGB), 32'h0);
      checkOutput("rel1_video", 32'(bus.video_on_out), 32'h0);
      step(1);
      checkOutput("rel2_rgb",   32'(bus.RGB), 32'hABC);
      checkOutput("rel2_video", 32'(bus.video_on_out), 32'h1);
      checkOutput("rel2_hsync", 32'(bus.hsync_out), 32'h0);
      checkOutput("rel2_vsync", 32'(bus.vsync_out), 32'h1);

      // Priority
      bus.layer_color = {12'h0F0, 12'h000, 12'hF00, 12'h000};
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b1010, 4'b0000, 1'b0);
      step(2);
      checkOutput("prio_l1", 32'(bus.RGB), 32'hF00);
      bus.layer_valid = 4'b1000;
      step(2);
      checkOutput("prio_l3", 32'(bus.RGB), 32'h0F0);
      bus.layer_valid = 4'b0000;
      step(2);
      checkOutput("prio_bg", 32'(bus.RGB), 32'h000);

      // Blanking
      bus.layer_color = {12'h000, 12'h000, 12'h000, 12'hFFF};
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0);
      step(2);
      for (int j = 0; j < 4; j++) begin
         bus.video_on = blank_vid[j][0];
         step(1);
         checkOutput($sformatf("blank_rgb%0d", j), 32'(bus.RGB), 32'(blank_exp[j]));
         checkOutput($sformatf("blank_vid%0d", j), 32'(bus.video_on_out), 32'(blank_exp[j] != 12'h000));
      end

      // 96-cycle hsync pulse
      bus.hsync_in = 1'b1;
      step(2);
      for (int j = 0; j < 100; j++) begin
         bus.hsync_in = (j < 96) ? 1'b0 : 1'b1;
         step(1);
         checkOutput($sformatf("hsync%0d", j), 32'(bus.hsync_out), (j >= 1 && j <= 96) ? 32'h0 : 32'h1);
      end

      // Blink with BLINK_FRAMES=2
      bus.layer_color = {12'h000, 12'h000, 12'h0F0, 12'h00F};
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b0011, 4'b0001, 1'b1);
      step(3);
      checkOutput("blink_start", 32'(bus.RGB), 32'h00F);
      vsyncPulse("p1", 1'b1, 1'b1);
      vsyncPulse("p2", 1'b0, 1'b1);
      vsyncPulse("p3", 1'b0, 1'b0);
      vsyncPulse("p4", 1'b1, 1'b0);
      vsyncPulse("p5", 1'b1, 1'b1);
      vsyncPulse("p6", 1'b0, 1'b1);

      // Blink disable
      bus.blink_en = 1'b0;
      step(1);
      checkOutput("dis_phase", 32'(bus.blink_phase), 32'h1);
      step(2);
      checkOutput("dis_rgb", 32'(bus.RGB), 32'h00F);
      vsyncPulse("d1", 1'b1, 1'b1);
      vsyncPulse("d2", 1'b1, 1'b1);
      bus.blink_en = 1'b1;
      step(1);
      vsyncPulse("e1", 1'b1, 1'b1);
      vsyncPulse("e2", 1'b0, 1'b1);
      vsyncPulse("e3", 1'b0, 1'b0);

      // Reset mid-blink: phase=0, count=1
      reset_n = 1'b0;
      #1;
      checkOutput("mrst_phase", 32'(bus.blink_phase), 32'h1);
      checkOutput("mrst_rgb",   32'(bus.RGB), 32'h0);
      checkOutput("mrst_video", 32'(bus.video_on_out), 32'h0);
      checkOutput("mrst_hsync", 32'(bus.hsync_out), 32'h1);
      @(negedge clk);
      reset_n = 1'b1;
      step(2);
      checkOutput("mrel_rgb", 32'(bus.RGB), 32'h00F);
      vsyncPulse("r1", 1'b1, 1'b1);
      vsyncPulse("r2", 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
